// File: rtl/freq_div_multi.sv
// Multi-channel programmable frequency divider.
// Each channel divides clock_50m by its own divisor and produces either a
// square wave (high for ceil(D/2) cycles) or a one-cycle pulse, plus a tick
// at the start of each period. A new divisor is staged in a pending register
// and only takes effect at a period boundary, so no period is ever truncated.
// A shared sync strobe forces every enabled channel to restart its period.

module freq_div_multi #(
    parameter int CH          = 4,
    parameter int DIV_W       = 20,
    parameter int DEFAULT_DIV = 500000
) (
    input  logic                clock_50m,
    input  logic                reset,
    input  logic [CH-1:0]       enable,
    input  logic [CH-1:0]       mode,
    input  logic [CH*DIV_W-1:0] divisor,
    input  logic [CH-1:0]       load,
    input  logic                sync,
    output logic [CH-1:0]       clk_out,
    output logic [CH-1:0]       tick
);

    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_D = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DIV_W-1:0] da;        // active divisor
        logic [DIV_W-1:0] dp;        // pending divisor
        logic             p;         // pending divisor waiting for a boundary
        logic [DIV_W-1:0] cnt;       // position within the current period
        logic             clk_q;
        logic             tick_q;

        logic [DIV_W-1:0] slice;
        logic [DIV_W-1:0] clamped;
        logic [DIV_W-1:0] pend_d;
        logic             pend_v;
        logic [DIV_W-1:0] next_da;
        logic             wrap;
        logic [DIV_W-1:0] cnt_next;
        logic [DIV_W-1:0] h_da;
        logic [DIV_W:0]   high_t;

        // Next-state helpers: clamped load value, divisor in force after a
        // boundary (a load on this very edge wins over the stored pending one),
        // and the high time measured against the post-wrap divisor.
        always_comb begin
            slice    = divisor[i*DIV_W +: DIV_W];
            clamped  = (slice < MIN_D) ? MIN_D : slice;
            pend_v   = load[i] | p;
            pend_d   = load[i] ? clamped : dp;
            next_da  = pend_v ? pend_d : da;
            wrap     = (cnt == da - ONE) | sync;
            cnt_next = wrap ? '0 : cnt + ONE;
            h_da     = wrap ? next_da : da;
            // Extra bit so that (D+1) cannot overflow for the largest divisor.
            high_t   = ({1'b0, h_da} + ONE_X) >> 1;
        end

        // Per-channel divider state and registered outputs.
        // NOTE: reset is synchronous and tested first, so it overrides load,
        // sync and enable on the same edge; all state updates are non-blocking.
        always_ff @(posedge clock_50m) begin
            if (reset) begin
                da     <= DEF_D;
                dp     <= DEF_D;
                p      <= 1'b0;
                cnt    <= DEF_D - ONE;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!enable[i]) begin
                // Idle: adopt any pending divisor now and park the counter on
                // the last count so the first enabled edge starts a new period.
                da     <= next_da;
                dp     <= pend_d;
                p      <= 1'b0;
                cnt    <= next_da - ONE;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt    <= cnt_next;
                tick_q <= wrap;
                clk_q  <= mode[i] ? wrap : ({1'b0, cnt_next} < high_t);
                if (wrap) begin
                    da <= next_da;
                    dp <= pend_d;
                    p  <= 1'b0;
                end else if (load[i]) begin
                    dp <= clamped;
                    p  <= 1'b1;
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Self-checking bench for freq_div_multi: directed scenarios against
// hand-derived sequences plus randomized traffic against a period-level
// reference model. DEFAULT_DIV is shortened so full periods after reset fit
// in a short run.

module tb_freq_div_multi;

    localparam int CH     = 4;
    localparam int DIV_W  = 20;
    localparam int TB_DEF = 1000;

    logic                clock_50m = 1'b0;
    logic                reset     = 1'b0;
    logic [CH-1:0]       enable    = '0;
    logic [CH-1:0]       mode      = '0;
    logic [CH*DIV_W-1:0] divisor   = '0;
    logic [CH-1:0]       load      = '0;
    logic                sync      = 1'b0;
    logic [CH-1:0]       clk_out;
    logic [CH-1:0]       tick;

    int n_checks = 0;
    int n_errors = 0;

    freq_div_multi #(
        .CH(CH),
        .DIV_W(DIV_W),
        .DEFAULT_DIV(TB_DEF)
    ) dut (
        .clock_50m(clock_50m),
        .reset(reset),
        .enable(enable),
        .mode(mode),
        .divisor(divisor),
        .load(load),
        .sync(sync),
        .clk_out(clk_out),
        .tick(tick)
    );

    always #10 clock_50m = ~clock_50m;

    // Reference model: each channel is a period of length D with a phase
    // position; the output is high for the first ceil(D/2) positions.
    int            m_period [CH];
    int            m_next   [CH];
    bit            m_staged [CH];
    int            m_phase  [CH];
    logic [CH-1:0] m_clk;
    logic [CH-1:0] m_tick;

    function automatic int clampd(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int req;
            int upcoming;
            req      = clampd(int'(divisor[c*DIV_W +: DIV_W]));
            upcoming = load[c] ? req : (m_staged[c] ? m_next[c] : m_period[c]);
            if (reset) begin
                m_period[c] = TB_DEF;
                m_staged[c] = 1'b0;
                m_phase[c]  = TB_DEF - 1;
                m_clk[c]    = 1'b0;
                m_tick[c]   = 1'b0;
            end else if (!enable[c]) begin
                m_period[c] = upcoming;
                m_staged[c] = 1'b0;
                m_phase[c]  = upcoming - 1;
                m_clk[c]    = 1'b0;
                m_tick[c]   = 1'b0;
            end else if (sync || m_phase[c] + 1 == m_period[c]) begin
                // A new period always starts at phase 0, which is high.
                m_period[c] = upcoming;
                m_staged[c] = 1'b0;
                m_phase[c]  = 0;
                m_tick[c]   = 1'b1;
                m_clk[c]    = 1'b1;
            end else begin
                m_phase[c] = m_phase[c] + 1;
                if (load[c]) begin
                    m_next[c]   = req;
                    m_staged[c] = 1'b1;
                end
                m_tick[c] = 1'b0;
                m_clk[c]  = mode[c] ? 1'b0 : (m_phase[c] < (m_period[c] + 1) / 2);
            end
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic cycle();
        @(posedge clock_50m);
        #1;
        model_step();
    endtask

    task automatic set_div(input int c, input int d);
        divisor[c*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = '0;
        mode   = '0;
        load   = '0;
        sync   = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = '1;
        mode    = '0;
        load    = '1;
        sync    = 1'b1;
        divisor = '0;
        cycle();
        n_checks++;
        if (clk_out !== '0) begin
            n_errors++;
            $display("FAIL reset_clk_out got=%b exp=%b", clk_out, {CH{1'b0}});
        end
        n_checks++;
        if (tick !== '0) begin
            n_errors++;
            $display("FAIL reset_tick got=%b exp=%b", tick, {CH{1'b0}});
        end
        reset  = 1'b0;
        enable = '0;
        load   = '0;
        sync   = 1'b0;
        cycle();
        n_checks++;
        if (clk_out !== '0 || tick !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset got clk=%b tick=%b exp=0/0", clk_out, tick);
        end
    endtask

    task automatic test_basic_d4();
        bit e_clk[5]  = '{1, 1, 0, 0, 1};
        bit e_tick[5] = '{1, 0, 0, 0, 1};
        do_reset();
        set_div(0, 4);
        load[0] = 1'b1;
        cycle();
        load[0]   = 1'b0;
        enable[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (clk_out[0] !== e_clk[k] || tick[0] !== e_tick[k]) begin
                n_errors++;
                $display("FAIL d4_seq k=%0d got clk=%b tick=%b exp clk=%b tick=%b",
                         k, clk_out[0], tick[0], e_clk[k], e_tick[k]);
            end
        end
    endtask

    task automatic test_odd_d5();
        do_reset();
        set_div(1, 5);
        load[1] = 1'b1;
        cycle();
        load[1]   = 1'b0;
        enable[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bit ec;
            bit et;
            ec = (k % 5) < 3;
            et = (k % 5) == 0;
            cycle();
            n_checks++;
            if (clk_out[1] !== ec || tick[1] !== et || clk_out[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL d5_seq k=%0d got clk=%b tick=%b ch0=%b exp clk=%b tick=%b ch0=0",
                         k, clk_out[1], tick[1], clk_out[0], ec, et);
            end
        end
    endtask

    task automatic test_reload();
        bit e_clk[11]  = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        bit e_tick[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        do_reset();
        set_div(0, 4);
        load[0] = 1'b1;
        cycle();
        load[0]   = 1'b0;
        enable[0] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 2) begin
                set_div(0, 6);
                load[0] = 1'b1;
            end else begin
                load[0] = 1'b0;
            end
            cycle();
            n_checks++;
            if (clk_out[0] !== e_clk[k] || tick[0] !== e_tick[k]) begin
                n_errors++;
                $display("FAIL reload_seq k=%0d got clk=%b tick=%b exp clk=%b tick=%b",
                         k, clk_out[0], tick[0], e_clk[k], e_tick[k]);
            end
        end
    endtask

    task automatic test_clamp();
        for (int dv = 0; dv < 2; dv++) begin
            do_reset();
            set_div(0, dv);
            load[0] = 1'b1;
            cycle();
            load[0]   = 1'b0;
            enable[0] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                bit e;
                e = (k % 2) == 0;
                cycle();
                n_checks++;
                if (clk_out[0] !== e || tick[0] !== e) begin
                    n_errors++;
                    $display("FAIL clamp_d%0d k=%0d got clk=%b tick=%b exp=%b",
                             dv, k, clk_out[0], tick[0], e);
                end
            end
        end
    endtask

    task automatic test_sync();
        do_reset();
        set_div(0, 4);
        set_div(1, 6);
        load[1:0] = 2'b11;
        cycle();
        load[1:0]   = 2'b00;
        enable[1:0] = 2'b11;
        repeat (3) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        n_checks++;
        if (clk_out[1:0] !== 2'b11 || tick[1:0] !== 2'b11 || clk_out[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL sync_edge got clk=%b tick=%b exp clk=x011 tick=xx11", clk_out, tick);
        end
        cycle();
        n_checks++;
        if (clk_out[1:0] !== 2'b11 || tick[1:0] !== 2'b00) begin
            n_errors++;
            $display("FAIL sync_after got clk=%b tick=%b exp clk=11 tick=00",
                     clk_out[1:0], tick[1:0]);
        end
    endtask

    task automatic test_reset_mid();
        int high;
        int period;
        do_reset();
        set_div(0, 6);
        load[0] = 1'b1;
        cycle();
        load[0]   = 1'b0;
        enable[0] = 1'b1;
        repeat (3) cycle();
        reset = 1'b1;
        set_div(0, 7);
        load[0] = 1'b1;
        sync    = 1'b1;
        cycle();
        n_checks++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid got clk=%b tick=%b exp 0/0", clk_out[0], tick[0]);
        end
        reset   = 1'b0;
        load[0] = 1'b0;
        sync    = 1'b0;
        cycle();
        n_checks++;
        if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_first got clk=%b tick=%b exp 1/1", clk_out[0], tick[0]);
        end
        high   = 1;
        period = -1;
        for (int i = 1; i <= 2 * TB_DEF; i++) begin
            cycle();
            if (tick[0] === 1'b1) begin
                period = i;
                break;
            end
            if (clk_out[0] === 1'b1) high++;
        end
        n_checks++;
        if (period != TB_DEF) begin
            n_errors++;
            $display("FAIL reset_mid_period got=%0d exp=%0d", period, TB_DEF);
        end
        n_checks++;
        if (high != TB_DEF / 2) begin
            n_errors++;
            $display("FAIL reset_mid_high got=%0d exp=%0d", high, TB_DEF / 2);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < CH; c++) begin
            set_div(c, int'($urandom_range(0, 9)));
        end
        load   = '1;
        enable = '0;
        cycle();
        enable = '1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 39) == 0) enable[c] = ~enable[c];
                if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
                load[c] = ($urandom_range(0, 9) == 0);
                if (load[c]) set_div(c, int'($urandom_range(0, 12)));
            end
            sync  = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 699) == 0);
            cycle();
            n_checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                n_errors++;
                if (bad < 10) begin
                    $display("FAIL random n=%0d got clk=%b tick=%b exp clk=%b tick=%b",
                             n, clk_out, tick, m_clk, m_tick);
                end
                bad++;
            end
        end
        reset = 1'b0;
        sync  = 1'b0;
        load  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_d4();
        test_odd_d5();
        test_reload();
        test_clamp();
        test_sync();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
